// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode sequencer for the digital clock.
// Synchronizes and debounces the mode button and three field buttons, steps
// clk_mode RUN -> SET_TIME -> SET_ALARM -> SET_DATE -> RUN on each mode press,
// forwards field presses only while an editor is active, and emits a one-cycle
// commit strobe when an editor is left via the mode button.
// Optional feature macro: AUTO_TIMEOUT_EN (idle abort of set modes back to RUN).
module clock_mode_ctrl #(
  parameter int DEB_TICKS    = 4,
  parameter int IDLE_TIMEOUT = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic [2:0] btn_raw,
  output logic [1:0] clk_mode,
  output logic [2:0] btn_pulse,
  output logic       load_time,
  output logic       load_alarm,
  output logic       load_date,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10,
    SET_DATE  = 2'b11
  } mode_e;

  localparam int CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_TICKS - 1);

  // Bit 0 is the mode button, bits 3:1 are field buttons 1..3.
  logic [3:0]       raw;
  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       stable;
  logic [3:0]       press;
  logic [CNT_W-1:0] deb_cnt [4];

  mode_e      state_q;
  mode_e      next_state;
  logic [2:0] load_n;
  logic [2:0] pulse_n;
  logic       mode_press;
  logic [2:0] field_press;

  assign raw         = {btn_raw, btn_mode};
  assign mode_press  = press[0];
  assign field_press = press[3:1];
  assign clk_mode    = state_q;

  // Two-flop synchronizer for all asynchronous button inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Per-button debounce: accept a new level after DEB_TICKS differing samples;
  // a rising acceptance yields a one-clock press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      press  <= '0;
      // NOTE: the debounce counters are a tiny array of control state, so they
      // are reset explicitly; large data memories would normally be left unreset.
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (tick) begin
          if (deb_cnt[i] == CNT_MAX) begin
            stable[i]  <= sync_b[i];
            press[i]   <= sync_b[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef AUTO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit;
  logic              timeout_n;

  assign timeout_hit = (state_q != RUN) && (idle_cnt == IDLE_MAX);

  // Idle counter: held at zero in RUN, cleared by any accepted press,
  // counts ticks in a set mode and saturates at IDLE_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || (state_q == RUN) || (|press)) begin
      idle_cnt <= '0;
    end else if (tick && (idle_cnt != IDLE_MAX)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Registered abort strobe.
  always_ff @(posedge clk) begin
    if (rst) timed_out <= 1'b0;
    else     timed_out <= timeout_n;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Next-state and output decode: mode press wins over timeout and field presses.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_state = state_q;
    load_n     = '0;
    pulse_n    = '0;
`ifdef AUTO_TIMEOUT_EN
    timeout_n  = 1'b0;
`endif
    if (mode_press) begin
      unique case (state_q)
        RUN:       next_state = SET_TIME;
        SET_TIME:  begin next_state = SET_ALARM; load_n[0] = 1'b1; end
        SET_ALARM: begin next_state = SET_DATE;  load_n[1] = 1'b1; end
        SET_DATE:  begin next_state = RUN;       load_n[2] = 1'b1; end
      endcase
    end
`ifdef AUTO_TIMEOUT_EN
    else if (timeout_hit) begin
      next_state = RUN;
      timeout_n  = 1'b1;
    end
`endif
    else if (state_q != RUN) begin
      pulse_n = field_press;
    end
  end

  // State and output registers; reset mid-edit drops any pending commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      btn_pulse  <= '0;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      load_date  <= 1'b0;
    end else begin
      state_q    <= next_state;
      btn_pulse  <= pulse_n;
      load_time  <= load_n[0];
      load_alarm <= load_n[1];
      load_date  <= load_n[2];
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: debounce thresholds, mode stepping,
// commit strobes, field gating, mode/field collision, idle timeout, reset mid-edit.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn_mode;
  logic [2:0] btn_raw;
  logic [1:0] clk_mode;
  logic [2:0] btn_pulse;
  logic       load_time;
  logic       load_alarm;
  logic       load_date;
  logic       timed_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters gathered by the monitor.
  int         n_lt = 0, n_la = 0, n_ld = 0, n_to = 0, n_mode_chg = 0;
  int         n_p [3] = '{0, 0, 0};
  int         seq = 0;
  logic [1:0] mode_at_lt = '0, mode_at_la = '0, mode_at_ld = '0;
  logic [1:0] prev_mode = '0;
  int         lt_before;

  clock_mode_ctrl #(.DEB_TICKS(4), .IDLE_TIMEOUT(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_raw    (btn_raw),
    .clk_mode   (clk_mode),
    .btn_pulse  (btn_pulse),
    .load_time  (load_time),
    .load_alarm (load_alarm),
    .load_date  (load_date),
    .timed_out  (timed_out)
  );

  always #5 clk = ~clk;

  // Tick: one clock high every four clocks.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Monitor sampled on the falling edge: counts strobe/pulse cycles and mode changes.
  always @(negedge clk) begin
    if (rst) begin
      prev_mode = 2'b00;
    end else begin
      if (clk_mode != prev_mode) n_mode_chg++;
      prev_mode = clk_mode;
      if (load_time)  begin n_lt++; mode_at_lt = clk_mode; seq = seq * 10 + 1; end
      if (load_alarm) begin n_la++; mode_at_la = clk_mode; seq = seq * 10 + 2; end
      if (load_date)  begin n_ld++; mode_at_ld = clk_mode; seq = seq * 10 + 3; end
      if (timed_out)  n_to++;
      for (int i = 0; i < 3; i++) if (btn_pulse[i]) n_p[i]++;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic press_mode(input int hold);
    btn_mode = 1'b1;
    wait_ticks(hold);
    btn_mode = 1'b0;
    wait_ticks(6);
  endtask

  task automatic press_field(input logic [2:0] pattern, input int hold);
    btn_raw = pattern;
    wait_ticks(hold);
    btn_raw = 3'b000;
    wait_ticks(6);
  endtask

  initial begin
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_raw  = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mode",    clk_mode, 2'b00);
    check("rst_pulse",   btn_pulse, 3'b000);
    check("rst_strobes", {load_time, load_alarm, load_date, timed_out}, 4'b0000);
    rst = 1'b0;

    // Idle for 100 ticks: nothing happens.
    wait_ticks(100);
    check("idle_mode",   clk_mode, 2'b00);
    check("idle_events", n_lt + n_la + n_ld + n_to + n_mode_chg + n_p[0] + n_p[1] + n_p[2], 0);

    // Debounce threshold: 3 ticks rejected, 5 ticks accepted once.
    press_mode(3);
    check("short_mode", clk_mode, 2'b00);
    check("short_chg",  n_mode_chg, 0);
    press_mode(5);
    check("long_mode",     clk_mode, 2'b01);
    check("long_chg",      n_mode_chg, 1);
    check("entry_no_load", n_lt + n_la + n_ld, 0);

    // Step through remaining modes; each exit commits on the leaving cycle.
    press_mode(5);
    check("mode_alarm",  clk_mode, 2'b10);
    check("lt_once",     n_lt, 1);
    check("lt_at_exit",  mode_at_lt, 2'b10);
    press_mode(5);
    check("mode_date",   clk_mode, 2'b11);
    check("la_once",     n_la, 1);
    check("la_at_exit",  mode_at_la, 2'b11);
    press_mode(5);
    check("mode_run",    clk_mode, 2'b00);
    check("ld_once",     n_ld, 1);
    check("ld_at_exit",  mode_at_ld, 2'b00);
    check("strobe_order", seq, 123);

    // Field gating: blocked in RUN, one-clock pulse in SET_TIME.
    press_field(3'b001, 5);
    check("run_gate",    n_p[0], 0);
    press_mode(5);
    check("enter_time",  clk_mode, 2'b01);
    press_field(3'b001, 5);
    check("b1_pulse",    n_p[0], 1);
    check("b23_quiet",   n_p[1] + n_p[2], 0);
    check("no_load_edit", n_lt, 1);

    // Mode and btn2 together in SET_ALARM: mode wins, btn2 held produces nothing later.
    press_mode(5);
    check("enter_alarm", clk_mode, 2'b10);
    btn_mode = 1'b1;
    btn_raw  = 3'b010;
    wait_ticks(5);
    btn_mode = 1'b0;
    btn_raw  = 3'b000;
    wait_ticks(6);
    check("coll_mode",   clk_mode, 2'b11);
    check("coll_load",   n_la, 2);
    check("coll_pulse",  n_p[1], 0);

    // Idle timeout in SET_DATE.
    wait_ticks(40);
    check("to_before",   clk_mode, 2'b11);
    wait_ticks(15);
`ifdef AUTO_TIMEOUT_EN
    check("to_mode",     clk_mode, 2'b00);
    check("to_strobe",   n_to, 1);
    check("to_no_load",  n_ld, 1);
`else
    check("hold_mode",   clk_mode, 2'b11);
    check("hold_no_to",  n_to, 0);
    press_mode(5);
    check("hold_exit",   clk_mode, 2'b00);
    check("hold_ld",     n_ld, 2);
`endif

    // Reset mid-edit discards the edit.
    press_mode(5);
    check("edit_enter",  clk_mode, 2'b01);
    lt_before = n_lt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_mode", clk_mode, 2'b00);
    check("mid_rst_load", load_time, 1'b0);
    rst = 1'b0;
    wait_ticks(5);
    check("mid_rst_mode2", clk_mode, 2'b00);
    check("mid_rst_nolt",  n_lt, lt_before);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
